// File: rtl/bank_mapper_sync.sv
// Cartridge bank mapper: synchronises the asynchronous bus strobes into FastClk
// and decodes I/O writes into live/shadow RAM and ROM-window bank registers.
module bank_mapper_sync #(
    parameter int         BANK_BITS   = 10,
    parameter int         NUM_WINDOWS = 2,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] REG_BASE    = 8'hD0
) (
    input  logic                 FastClk,
    input  logic                 nReset,
    input  logic                 nSel,
    input  logic                 nIO,
    input  logic                 nWE,
    input  logic [3:0]           AddrHi,
    input  logic [3:0]           AddrLo,
    input  logic [7:0]           WriteData,
    output logic [7:0]           RegOut,
    output logic                 RegAck,
    output logic [BANK_BITS-1:0] WindowBank,
    output logic                 WindowHit,
    output logic                 WindowIsRam,
    output logic                 MapUpdated,
    output logic                 Staged
);
    localparam int NUM_BANKS = NUM_WINDOWS + 1;
    localparam int BUS_W     = 19;
    // Bus vector layout: {nWE, nSel, nIO, AddrHi, AddrLo, WriteData}
    localparam logic [BUS_W-1:0] BUS_IDLE = {3'b111, 16'h0000};

    logic [BUS_W-1:0]     sync_q [SYNC_STAGES];
    logic [BUS_W-1:0]     sync_d [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] valid_q, valid_d;
    logic                 nwe_prev_q, nwe_prev_d;
    logic                 armed_q, armed_d;
    logic [7:0]           cap_addr_q, cap_addr_d;
    logic [7:0]           cap_data_q, cap_data_d;
    logic                 cap_iowr_q, cap_iowr_d;
    logic [BANK_BITS-1:0] live_q [NUM_BANKS];
    logic [BANK_BITS-1:0] live_d [NUM_BANKS];
    logic [BANK_BITS-1:0] shadow_q [NUM_BANKS];
    logic [BANK_BITS-1:0] shadow_d [NUM_BANKS];
    logic                 staged_q, staged_d;
    logic                 map_upd_q, map_upd_d;

    logic [BUS_W-1:0]     bus_s;
    logic                 nwe_s;
    logic                 wr_evt;
    logic [15:0]          rd_word;

    function automatic logic [BANK_BITS-1:0] merge_byte(input logic [BANK_BITS-1:0] old,
                                                        input logic hi,
                                                        input logic [7:0] data);
        logic [15:0] w;
        w = 16'(old);
        if (hi) w[15:8] = data;
        else    w[7:0]  = data;
        return w[BANK_BITS-1:0];
    endfunction

    // Synchroniser chain plus capture; a write is only armed once a genuinely
    // sampled idle nWE has been seen, so a write interrupted by reset is dropped.
    always_comb begin
        sync_d[0] = {nWE, nSel, nIO, AddrHi, AddrLo, WriteData};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        valid_d    = {valid_q[SYNC_STAGES-2:0], 1'b1};
        bus_s      = sync_q[SYNC_STAGES-1];
        nwe_s      = bus_s[18];
        nwe_prev_d = nwe_s;
        armed_d    = armed_q | (valid_q[SYNC_STAGES-1] & nwe_s);
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        cap_iowr_d = cap_iowr_q;
        if (armed_q && !nwe_s) begin
            cap_addr_d = bus_s[15:8];
            cap_data_d = bus_s[7:0];
            cap_iowr_d = ~bus_s[17] & ~bus_s[16];
        end
        wr_evt = armed_q & nwe_s & ~nwe_prev_q & cap_iowr_q;
    end

    always_comb begin
        live_d    = live_q;
        shadow_d  = shadow_q;
        staged_d  = staged_q;
        map_upd_d = 1'b0;
        if (wr_evt && cap_addr_q[7:4] == REG_BASE[7:4]) begin
            if (cap_addr_q[3:0] == 4'hF) begin
                live_d = shadow_q;
            end else if (cap_addr_q[3:0] == 4'hE) begin
                staged_d = cap_data_q[0];
            end else begin
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (cap_addr_q[3:1] == 3'(i)) begin
                        shadow_d[i] = merge_byte(shadow_q[i], cap_addr_q[0], cap_data_q);
                        if (!staged_q)
                            live_d[i] = merge_byte(live_q[i], cap_addr_q[0], cap_data_q);
                    end
                end
            end
        end
        for (int i = 0; i < NUM_BANKS; i++)
            if (live_d[i] != live_q[i]) map_upd_d = 1'b1;
    end

    // Readback and window lookup are combinational from the raw bus address.
    always_comb begin
        RegOut      = 8'h00;
        RegAck      = 1'b0;
        rd_word     = 16'h0000;
        WindowBank  = '0;
        WindowHit   = 1'b0;
        WindowIsRam = (AddrHi == 4'd1);
        if (AddrHi == REG_BASE[7:4]) begin
            if (AddrLo == 4'hE) begin
                RegAck = 1'b1;
                RegOut = {7'b0, staged_q};
            end else if (AddrLo == 4'hF) begin
                RegAck = 1'b1;
            end else begin
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (AddrLo[3:1] == 3'(i)) begin
                        RegAck  = 1'b1;
                        rd_word = 16'(live_q[i]);
                        RegOut  = AddrLo[0] ? rd_word[15:8] : rd_word[7:0];
                    end
                end
            end
        end
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (AddrHi == 4'(i + 1)) begin
                WindowBank = live_q[i];
                WindowHit  = 1'b1;
            end
        end
    end

    always_ff @(posedge FastClk) begin
        if (!nReset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= BUS_IDLE;
            valid_q    <= '0;
            nwe_prev_q <= 1'b1;
            armed_q    <= 1'b0;
            cap_addr_q <= 8'h00;
            cap_data_q <= 8'h00;
            cap_iowr_q <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                live_q[i]   <= '1;
                shadow_q[i] <= '1;
            end
            staged_q  <= 1'b0;
            map_upd_q <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            valid_q    <= valid_d;
            nwe_prev_q <= nwe_prev_d;
            armed_q    <= armed_d;
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            cap_iowr_q <= cap_iowr_d;
            for (int i = 0; i < NUM_BANKS; i++) begin
                live_q[i]   <= live_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            staged_q  <= staged_d;
            map_upd_q <= map_upd_d;
        end
    end

    assign MapUpdated = map_upd_q;
    assign Staged     = staged_q;

endmodule
